palette_lookup_arbiter: RTL and testbench
=========================================

# palette_lookup_arbiter

Shared palette lookup engine for the sprite renderers. It holds a bank of 8 writable 8-entry, 12-bit RGB palettes and lets NUM_REQ renderers share one lookup port. Requesters (player, enemy and bullet pixel pipelines) present {palette id, colour index}; one lookup is granted per cycle in round-robin order, and the resulting RGB returns one cycle later with a requester tag. A configuration port loads palette contents at run time and replaces per-sprite hard-wired palette ROMs.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  lookup request per requester
- req_pal  in  NUM_REQ*3  palette id per requester, requester i at bits [3i+2:3i]
- req_index  in  NUM_REQ*3  colour index per requester, same packing
- req_ready  out  NUM_REQ  grant; transfer occurs when valid&ready
- cfg_we  in  1  palette write strobe
- cfg_pal  in  3  palette id to write
- cfg_index  in  3  entry to write
- cfg_rgb  in  12  {red, green, blue} nibbles
- rsp_valid  out  1  response strobe, one cycle wide
- rsp_id  out  $clog2(NUM_REQ)  requester that owns the response
- rsp_red, rsp_green, rsp_blue  out  4 each  looked-up colour
- rsp_transparent  out  1  high when the looked-up index was 0

## Operation
- Storage: 64 x 12-bit registers addressed by {pal, index}. Reset clears every entry to 12'h000.
- Config write: when cfg_we=1, entry {cfg_pal, cfg_index} takes cfg_rgb at the end of that cycle. Config has absolute priority: req_ready is all-zero in any cycle with cfg_we=1.
- Arbitration: round-robin pointer ptr, reset value 0. When cfg_we=0, the arbiter grants the first i with req_valid[i]=1, searching ptr, ptr+1, … mod NUM_REQ. Exactly one bit of req_ready is high in a granting cycle; none are high otherwise.
- After a grant to i, ptr becomes (i+1) mod NUM_REQ. With no grant, ptr holds.
- req_ready is combinational from req_valid, cfg_we and ptr. Requesters must not derive req_valid from req_ready. Requesters hold valid and payload stable until granted.
- Response: registers capture the granted id, the stored RGB and (index==0). No backpressure: a renderer must accept rsp_valid in the cycle it appears.
- Transparency: rsp_transparent=1 for index 0. RGB is still the stored value, and the compositor ignores it.

## Timing
- Lookup latency is exactly 1 cycle: a grant in cycle t gives rsp_valid=1 in cycle t+1. Sustained throughput is one lookup per cycle.
- Read-after-write: a write in cycle t is visible to lookups granted in t+1 or later. No lookup is granted in t itself.
- Back-to-back writes: each write blocks grants for its cycle only. Continuous cfg_we starves all requesters. This is legal and used during load at vertical blank.
- Reset values: rsp_valid=0, rsp_id=0, rsp_red/green/blue=0, rsp_transparent=0, ptr=0, memory all zero.
- req_ready is combinational, so during reset it is 0 only if req_valid is 0.
- Reset asserted mid-operation: all outputs clear asynchronously, and any in-flight response is dropped, not replayed. After release, arbitration restarts at requester 0.
- Writes and requests arriving at the Reset_n release edge are ignored. The first cycle after release is normal.

## Structure
- The package palette_pkg holds:
  - PAL_ID_W=3 and PAL_IDX_W=3
  - the typedef rgb12_t as a packed struct {logic [3:0] r, g, b}
  - the lookup request struct {pal, index}
- Sub-module rr_arbiter (parameter N) holds the rotating pointer and produces a one-hot grant from a request vector and an enable (enable = !cfg_we).
- The top level holds the storage, the config write and the response register.

## Test plan
- Reset, write pal 2 idx 5 = 12'hC20, then drive req 1 {pal 2, idx 5} → req_ready=4'b0010 that cycle; next cycle rsp_valid=1, rsp_id=1, rgb=C,2,0, rsp_transparent=0.
- All four requesters valid continuously for 8 cycles → grant order 0,1,2,3,0,1,2,3 and rsp_id follows, delayed by one cycle.
- cfg_we=1 writing pal 0 idx 1 = 12'h0E1 while req 0 asks {0,1} → req_ready=0 that cycle; req 0 is granted the next cycle and returns 0,E,1.
- Request {pal 3, idx 0} after writing 12'hFFF there → rsp_transparent=1, rgb=F,F,F.
- Only requesters 1 and 3 valid with ptr=2 → requester 3 granted first, then 1 in the following cycle, then 3 again.
- Drop Reset_n while rsp_valid=1 → rsp_valid and rgb are 0 in the same cycle. After release, any prior lookup returns 0,0,0 and the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/palette_pkg.sv
// Shared types for the palette lookup engine:
// palette geometry, RGB nibble triple and lookup request.
package palette_pkg;

    localparam int PAL_ID_W   = 3;
    localparam int PAL_IDX_W  = 3;
    localparam int PAL_ADDR_W = PAL_ID_W + PAL_IDX_W;
    localparam int PAL_DEPTH  = 1 << PAL_ADDR_W;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12_t;

    typedef struct packed {
        logic [PAL_ID_W-1:0]  pal;
        logic [PAL_IDX_W-1:0] index;
    } lookup_req_t;

    function automatic logic [PAL_ADDR_W-1:0] pal_addr(
        input lookup_req_t q
    );
        return {q.pal, q.index};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant from a request vector,
// search starts at a rotating pointer that moves past each winner.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_id,
    output logic          gnt_any
);

    logic [IW-1:0] ptr;

    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_id  = '0;
        gnt_any = 1'b0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                j = int'(ptr) + k;
                if (j >= N) j = j - N;
                if (!gnt_any && req[j]) begin
                    gnt[j]  = 1'b1;
                    gnt_id  = IW'(j);
                    gnt_any = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_id == IW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

endmodule

// File: rtl/palette_lookup_arbiter.sv
// Shared 8x8-entry 12-bit palette bank with a round-robin lookup
// port; config writes pre-empt lookups, responses arrive next cycle.
module palette_lookup_arbiter
    import palette_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*3-1:0]   req_pal,
    input  logic [NUM_REQ*3-1:0]   req_index,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   cfg_we,
    input  logic [2:0]             cfg_pal,
    input  logic [2:0]             cfg_index,
    input  logic [11:0]            cfg_rgb,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [3:0]             rsp_red,
    output logic [3:0]             rsp_green,
    output logic [3:0]             rsp_blue,
    output logic                   rsp_transparent
);

    lookup_req_t     reqs [NUM_REQ];
    lookup_req_t     sel;
    rgb12_t          mem  [PAL_DEPTH];
    rgb12_t          rd_rgb;
    rgb12_t          rsp_rgb;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_any;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            reqs[i].pal   = req_pal[3*i +: 3];
            reqs[i].index = req_index[3*i +: 3];
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_arb (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .en      (!cfg_we),
        .req     (req_valid),
        .gnt     (req_ready),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign sel    = reqs[gnt_id];
    assign rd_rgb = mem[pal_addr(sel)];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int a = 0; a < PAL_DEPTH; a++) begin
                mem[a] <= '0;
            end
        end else if (cfg_we) begin
            mem[{cfg_pal, cfg_index}] <= rgb12_t'(cfg_rgb);
        end
    end

    // payload is only refreshed on a grant; rsp_valid qualifies it
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_rgb         <= '0;
            rsp_transparent <= 1'b0;
        end else begin
            rsp_valid <= gnt_any;
            if (gnt_any) begin
                rsp_id          <= gnt_id;
                rsp_rgb         <= rd_rgb;
                rsp_transparent <= (sel.index == '0);
            end
        end
    end

    assign rsp_red   = rsp_rgb.r;
    assign rsp_green = rsp_rgb.g;
    assign rsp_blue  = rsp_rgb.b;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Scoreboard bench for palette_lookup_arbiter with four requesters.
// A reference model predicts grants and responses cycle by cycle.
module tb_palette_lookup_arbiter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [3:0]  req_valid;
    logic [11:0] req_pal;
    logic [11:0] req_index;
    logic [3:0]  req_ready;
    logic        cfg_we;
    logic [2:0]  cfg_pal;
    logic [2:0]  cfg_index;
    logic [11:0] cfg_rgb;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_red;
    logic [3:0]  rsp_green;
    logic [3:0]  rsp_blue;
    logic        rsp_transparent;

    logic [2:0]  tpal [4];
    logic [2:0]  tidx [4];

    typedef struct {
        logic        v;
        logic [1:0]  id;
        logic [11:0] rgb;
        logic        tr;
    } exp_t;

    exp_t        sb [$];
    logic [11:0] mmem [64];
    int          mptr;
    int          vec;
    int          err;
    logic [3:0]  eg;

    always #5 Clk = ~Clk;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_pal[3*i +: 3]   = tpal[i];
            req_index[3*i +: 3] = tidx[i];
        end
    end

    palette_lookup_arbiter #(.NUM_REQ(4)) dut (
        .Clk             (Clk),
        .Reset_n         (Reset_n),
        .req_valid       (req_valid),
        .req_pal         (req_pal),
        .req_index       (req_index),
        .req_ready       (req_ready),
        .cfg_we          (cfg_we),
        .cfg_pal         (cfg_pal),
        .cfg_index       (cfg_index),
        .cfg_rgb         (cfg_rgb),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_red         (rsp_red),
        .rsp_green       (rsp_green),
        .rsp_blue        (rsp_blue),
        .rsp_transparent (rsp_transparent)
    );

    // response checker: one expectation per modelled cycle
    always @(posedge Clk) begin
        exp_t e;
        #2;
        if (Reset_n && sb.size() > 0) begin
            e = sb.pop_front();
            vec++;
            if (rsp_valid !== e.v ||
                (e.v && ({rsp_id, rsp_red, rsp_green, rsp_blue,
                          rsp_transparent} !== {e.id, e.rgb, e.tr}))) begin
                err++;
                $display("FAIL rsp @%0t: got v=%b id=%0d rgb=%h t=%b, want v=%b id=%0d rgb=%h t=%b",
                         $time, rsp_valid, rsp_id,
                         {rsp_red, rsp_green, rsp_blue}, rsp_transparent,
                         e.v, e.id, e.rgb, e.tr);
            end
        end
    end

    // called at posedge+1 with inputs set; returns at posedge+4
    task automatic model_cycle(output logic [3:0] g);
        exp_t e;
        int   j;
        #3;
        g = '0;
        e = '{v: 1'b0, id: 2'd0, rgb: 12'h000, tr: 1'b0};
        if (!cfg_we) begin
            for (int k = 0; k < 4; k++) begin
                j = (mptr + k) % 4;
                if (g == 4'b0 && req_valid[j]) begin
                    g[j]  = 1'b1;
                    e.v   = 1'b1;
                    e.id  = 2'(j);
                    e.rgb = mmem[{tpal[j], tidx[j]}];
                    e.tr  = (tidx[j] == 3'd0);
                end
            end
        end
        if (e.v) mptr = (int'(e.id) + 1) % 4;
        if (cfg_we) mmem[{cfg_pal, cfg_index}] = cfg_rgb;
        sb.push_back(e);
    endtask

    task automatic advance();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        cfg_we    = 1'b0;
        cfg_pal   = '0;
        cfg_index = '0;
        cfg_rgb   = '0;
        for (int i = 0; i < 4; i++) begin
            tpal[i] = '0;
            tidx[i] = '0;
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle_inputs();
        mptr = 0;
        for (int a = 0; a < 64; a++) mmem[a] = '0;
        #12;
        vec++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue,
             rsp_transparent, req_ready} !== 21'd0) begin
            err++;
            $display("FAIL reset_state: got v=%b id=%0d rgb=%h t=%b rdy=%b, want all zero",
                     rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue},
                     rsp_transparent, req_ready);
        end
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
    endtask

    task automatic test_round_robin();
        logic [3:0] want;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tpal[i] = 3'(i);
            tidx[i] = 3'(i + 1);
        end
        for (int c = 0; c < 8; c++) begin
            model_cycle(eg);
            want = 4'b0001 << (c % 4);
            vec++;
            if (req_ready !== want || req_ready !== eg) begin
                err++;
                $display("FAIL rr_order[%0d]: got %b want %b", c, req_ready, want);
            end
            advance();
        end
        idle_inputs();
        model_cycle(eg);
        advance();
    endtask

    task automatic test_write_read();
        cfg_we    = 1'b1;
        cfg_pal   = 3'd2;
        cfg_index = 3'd5;
        cfg_rgb   = 12'hC20;
        model_cycle(eg);
        vec++;
        if (req_ready !== 4'b0000) begin
            err++;
            $display("FAIL wr_ready: got %b want 0000", req_ready);
        end
        advance();
        idle_inputs();
        req_valid = 4'b0010;
        tpal[1]   = 3'd2;
        tidx[1]   = 3'd5;
        model_cycle(eg);
        vec++;
        if (req_ready !== 4'b0010 || req_ready !== eg) begin
            err++;
            $display("FAIL rd_ready: got %b want 0010", req_ready);
        end
        advance();
        idle_inputs();
        vec++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent}
            !== {1'b1, 2'd1, 12'hC20, 1'b0}) begin
            err++;
            $display("FAIL rd_rsp: got v=%b id=%0d rgb=%h t=%b want v=1 id=1 rgb=c20 t=0",
                     rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent);
        end
        model_cycle(eg);
        advance();
    endtask

    task automatic test_rr_skip();
        logic [3:0] want [3];
        want[0] = 4'b1000;
        want[1] = 4'b0010;
        want[2] = 4'b1000;
        tpal[1] = 3'd2; tidx[1] = 3'd5;
        tpal[3] = 3'd4; tidx[3] = 3'd7;
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1010;
            model_cycle(eg);
            vec++;
            if (req_ready !== want[c] || req_ready !== eg) begin
                err++;
                $display("FAIL rr_skip[%0d]: got %b want %b", c, req_ready, want[c]);
            end
            advance();
        end
        idle_inputs();
        model_cycle(eg);
        advance();
    endtask

    task automatic test_cfg_priority();
        cfg_we    = 1'b1;
        cfg_pal   = 3'd0;
        cfg_index = 3'd1;
        cfg_rgb   = 12'h0E1;
        req_valid = 4'b0001;
        tpal[0]   = 3'd0;
        tidx[0]   = 3'd1;
        model_cycle(eg);
        vec++;
        if (req_ready !== 4'b0000) begin
            err++;
            $display("FAIL cfg_block: got %b want 0000", req_ready);
        end
        advance();
        cfg_we = 1'b0;
        model_cycle(eg);
        vec++;
        if (req_ready !== 4'b0001 || req_ready !== eg) begin
            err++;
            $display("FAIL cfg_after: got %b want 0001", req_ready);
        end
        advance();
        idle_inputs();
        vec++;
        if ({rsp_valid, rsp_red, rsp_green, rsp_blue} !== {1'b1, 12'h0E1}) begin
            err++;
            $display("FAIL cfg_rgb: got v=%b rgb=%h want v=1 rgb=0e1",
                     rsp_valid, {rsp_red, rsp_green, rsp_blue});
        end
        model_cycle(eg);
        advance();
    endtask

    task automatic test_transparent();
        cfg_we    = 1'b1;
        cfg_pal   = 3'd3;
        cfg_index = 3'd0;
        cfg_rgb   = 12'hFFF;
        model_cycle(eg);
        advance();
        idle_inputs();
        req_valid = 4'b0100;
        tpal[2]   = 3'd3;
        tidx[2]   = 3'd0;
        model_cycle(eg);
        advance();
        idle_inputs();
        vec++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent}
            !== {1'b1, 2'd2, 12'hFFF, 1'b1}) begin
            err++;
            $display("FAIL transparent: got v=%b id=%0d rgb=%h t=%b want v=1 id=2 rgb=fff t=1",
                     rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent);
        end
        model_cycle(eg);
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!req_valid[i] && $urandom_range(1) == 1) begin
                    req_valid[i] = 1'b1;
                    tpal[i]      = 3'($urandom);
                    tidx[i]      = 3'($urandom);
                end
            end
            cfg_we    = ($urandom_range(3) == 0);
            cfg_pal   = 3'($urandom);
            cfg_index = 3'($urandom);
            cfg_rgb   = 12'($urandom);
            model_cycle(eg);
            vec++;
            if (req_ready !== eg) begin
                err++;
                $display("FAIL rand_ready[%0d]: got %b want %b", c, req_ready, eg);
            end
            advance();
            req_valid = req_valid & ~eg;
        end
        idle_inputs();
        model_cycle(eg);
        advance();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0010;
        tpal[1]   = 3'd2;
        tidx[1]   = 3'd5;
        model_cycle(eg);
        advance();
        idle_inputs();
        #2;
        vec++;
        if (rsp_valid !== 1'b1) begin
            err++;
            $display("FAIL mid_pre: got rsp_valid=%b want 1", rsp_valid);
        end
        Reset_n = 1'b0;
        #1;
        vec++;
        if ({rsp_valid, rsp_id, rsp_red, rsp_green, rsp_blue, rsp_transparent} !== 19'd0) begin
            err++;
            $display("FAIL mid_clear: got v=%b id=%0d rgb=%h t=%b want all zero",
                     rsp_valid, rsp_id, {rsp_red, rsp_green, rsp_blue}, rsp_transparent);
        end
        sb.delete();
        mptr = 0;
        for (int a = 0; a < 64; a++) mmem[a] = '0;
        req_valid = 4'b1010;
        tpal[1] = 3'd2; tidx[1] = 3'd5;
        tpal[3] = 3'd3; tidx[3] = 3'd0;
        advance();
        advance();
        vec++;
        if (req_ready !== 4'b0010) begin
            err++;
            $display("FAIL mid_rst_ready: got %b want 0010", req_ready);
        end
        Reset_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            model_cycle(eg);
            vec++;
            if (req_ready !== (c == 0 ? 4'b0010 : 4'b1000) || req_ready !== eg) begin
                err++;
                $display("FAIL mid_after[%0d]: got %b want %b", c, req_ready,
                         (c == 0 ? 4'b0010 : 4'b1000));
            end
            advance();
            req_valid = req_valid & ~eg;
        end
        idle_inputs();
        model_cycle(eg);
        advance();
        model_cycle(eg);
        advance();
    endtask

    initial begin
        vec = 0;
        err = 0;
        test_reset();
        test_round_robin();
        test_write_read();
        test_rr_skip();
        test_cfg_priority();
        test_transparent();
        test_random();
        test_reset_mid();
        #4;
        if (sb.size() != 0) begin
            vec++;
            err++;
            $display("FAIL drain: %0d expected responses never checked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
